instruction_ram_loader: RTL

- Writer side of the instruction memory: receives a byte stream (boot/host link), packs it into 32-bit instruction words and issues one-cycle write strobes into instruction RAM at ascending addresses.
- Holds the core stalled, via busy, while loading.
- Replaces the fixed first-clock preload with a runtime program load.

---
 rtl/instruction_ram_loader.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/instruction_ram_loader.sv
// instruction_ram_loader: packs a boot byte stream into 32-bit words and
// writes them into instruction RAM at ascending addresses.
// Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
module instruction_ram_loader #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DEPTH         = 160
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     byte_valid,
    input  logic [7:0]               byte_data,
    output logic                     byte_ready,
    output logic                     write_enable,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [31:0]              write_data,
    output logic                     busy,
    output logic                     load_done,
    output logic                     load_error
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT_HI,
        S_COUNT_LO,
        S_COLLECT,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT_HI,
        S_COUNT_LO,
        S_COLLECT,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;
`endif

    state_t                   r_state;
    state_t                   w_next;

    logic [15:0]              r_count;
    logic [ADDRESS_WIDTH:0]   r_word_idx;
    logic [1:0]               r_byte_idx;
    logic [23:0]              r_word;
    logic [ADDRESS_WIDTH-1:0] r_wr_addr;
    logic [31:0]              r_wr_data;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]               r_xor;
`endif

    logic                     w_fire;
    logic                     w_start_ok;
    logic [15:0]              w_count_full;
    logic                     w_n_zero;
    logic                     w_n_over;
    logic [ADDRESS_WIDTH:0]   w_idx_next;
    logic                     w_last;

    assign w_fire       = byte_valid && byte_ready;
    assign w_start_ok   = start && ((r_state == S_IDLE) ||
                                    (r_state == S_DONE) ||
                                    (r_state == S_ERROR));
    assign w_count_full = {r_count[15:8], byte_data};
    assign w_n_zero     = (w_count_full == 16'd0);
    assign w_n_over     = ({16'd0, w_count_full} > 32'(DEPTH));
    assign w_idx_next   = r_word_idx + {{ADDRESS_WIDTH{1'b0}}, 1'b1};
    assign w_last       = (32'(w_idx_next) == {16'd0, r_count});

    assign write_address = r_wr_addr;
    assign write_data    = r_wr_data;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and state-decoded outputs
    always_comb begin
        w_next       = r_state;
        byte_ready   = 1'b0;
        write_enable = 1'b0;
        busy         = 1'b0;
        load_done    = 1'b0;
        load_error   = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_COUNT_HI;
                end
            end
            S_COUNT_HI: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    w_next = S_COUNT_LO;
                end
            end
            S_COUNT_LO: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    if (w_n_zero) begin
                        w_next = S_DONE;
                    end else if (w_n_over) begin
                        w_next = S_ERROR;
                    end else begin
                        w_next = S_COLLECT;
                    end
                end
            end
            S_COLLECT: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid && (r_byte_idx == 2'd3)) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                write_enable = 1'b1;
                busy         = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                w_next = w_last ? S_CHECK : S_COLLECT;
`else
                w_next = w_last ? S_DONE : S_COLLECT;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                if (byte_valid) begin
                    w_next = (byte_data == r_xor) ? S_DONE : S_ERROR;
                end
            end
`endif
            S_DONE: begin
                load_done = 1'b1;
                if (start) begin
                    w_next = S_COUNT_HI;
                end
            end
            S_ERROR: begin
                load_error = 1'b1;
                if (start) begin
                    w_next = S_COUNT_HI;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Count capture, word assembly and write-port registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count    <= 16'd0;
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_word     <= 24'd0;
            r_wr_addr  <= '0;
            r_wr_data  <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            r_xor      <= 8'd0;
`endif
        end else begin
            if (w_start_ok) begin
                r_count    <= 16'd0;
                r_word_idx <= '0;
                r_byte_idx <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                r_xor      <= 8'd0;
`endif
            end
            if (w_fire) begin
                case (r_state)
                    S_COUNT_HI: begin
                        r_count[15:8] <= byte_data;
                    end
                    S_COUNT_LO: begin
                        r_count[7:0] <= byte_data;
                        r_word_idx   <= '0;
                        r_byte_idx   <= 2'd0;
                    end
                    S_COLLECT: begin
                        r_word     <= {r_word[15:0], byte_data};
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ byte_data;
`endif
                        if (r_byte_idx == 2'd3) begin
                            r_wr_data <= {r_word, byte_data};
                            r_wr_addr <= r_word_idx[ADDRESS_WIDTH-1:0];
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (r_state == S_WRITE) begin
                r_word_idx <= w_idx_next;
            end
        end
    end

endmodule
